// File: rtl/corner_list_fifo.sv
// corner_list_fifo: buffers NMS corner pulses as a valid/ready word stream and appends a per-frame count trailer.
module corner_list_fifo #(
  parameter int COL_NUM = 640,
  parameter int ROW_NUM = 480,
  parameter int DEPTH   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iscorner,
  input  logic [9:0]               x_coord,
  input  logic [9:0]               y_coord,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              m_data,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d, mem_cnt;
  logic [32:0]   out_q, wdata;
  logic          out_v_q, prev_q, pend_q, ovf_q;
  logic [15:0]   ccnt_q, dcnt_q, ccnt_n, dcnt_n;
  logic [31:0]   trl_q;
  logic          match, eof, full, trl_wr, cor_wr, drop, wr, pop, load;
  always_comb begin
    match   = x_coord == 10'(COL_NUM - 1) && y_coord == 10'(ROW_NUM - 1);
    eof     = match && !prev_q;
    full    = level_q == LW'(DEPTH);
    trl_wr  = pend_q && !full;
    cor_wr  = iscorner && !full && !trl_wr;
    drop    = iscorner && !cor_wr;
    wr      = trl_wr || cor_wr;
    wdata   = trl_wr ? {1'b1, trl_q} : {1'b0, 12'h000, y_coord, x_coord};
    pop     = out_v_q && m_ready;
    mem_cnt = level_q - LW'(out_v_q);
    load    = mem_cnt != '0 && (!out_v_q || pop);
    ccnt_n  = ccnt_q + 16'(cor_wr && !(&ccnt_q));
    dcnt_n  = dcnt_q + 16'(drop && !(&dcnt_q));
    level_d = level_q + LW'(wr) - LW'(pop);
  end
  // Memory holds no reset; only pointers and the output register define content.
  always_ff @(posedge clk)
    if (!rst && wr) mem[wptr_q] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      prev_q  <= 1'b1;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ccnt_q  <= '0;
      dcnt_q  <= '0;
      trl_q   <= '0;
    end else begin
      prev_q  <= match;
      ovf_q   <= ovf_q | drop;
      ccnt_q  <= eof ? '0 : ccnt_n;
      dcnt_q  <= eof ? '0 : dcnt_n;
      pend_q  <= eof | (pend_q & !trl_wr);
      level_q <= level_d;
      out_v_q <= load | (out_v_q & !pop);
      if (eof) trl_q <= {dcnt_n, ccnt_n};
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (load) begin
        rptr_q <= rptr_q + 1'b1;
        out_q  <= mem[rptr_q];
      end
    end
  end
  assign m_valid  = out_v_q;
  assign m_last   = out_q[32];
  assign m_data   = out_q[31:0];
  assign level    = level_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_corner_list_fifo.sv
// tb_corner_list_fifo: directed raster scenarios on a 16x8 frame with an 8-word FIFO.
module tb_corner_list_fifo;
  localparam int C = 16;
  localparam int R = 8;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst, iscorner, m_ready, m_valid, m_last, overflow;
  logic [9:0] x_coord, y_coord;
  logic [31:0] m_data;
  logic [3:0] level;
  int total = 0, bad = 0;
  bit cmask [128];
  logic [32:0] got [$];
  always #5 clk = ~clk;
  corner_list_fifo #(.COL_NUM(C), .ROW_NUM(R), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .iscorner(iscorner), .x_coord(x_coord), .y_coord(y_coord),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .level(level), .overflow(overflow)
  );
  always @(posedge clk)
    if (!rst && m_valid && m_ready) got.push_back({m_last, m_data});
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_pix(input int idx, input bit c);
    x_coord = 10'(idx % C);
    y_coord = 10'(idx / C);
    iscorner = c;
  endtask
  task automatic pixels(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      set_pix(i, cmask[i]);
      step();
    end
    set_pix(0, 1'b0);
  endtask
  task automatic idle(input int n);
    set_pix(0, 1'b0);
    repeat (n) step();
  endtask
  task automatic do_reset;
    rst = 1'b1;
    m_ready = 1'b0;
    set_pix(0, 1'b0);
    foreach (cmask[i]) cmask[i] = 1'b0;
    step();
    step();
    rst = 1'b0;
    got.delete();
  endtask
  task automatic test_reset;
    do_reset();
    total += 5;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    if (m_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", m_last); end
    if (m_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", m_data); end
    if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask
  task automatic test_basic;
    logic [32:0] exp [$];
    logic [32:0] g;
    do_reset();
    m_ready = 1'b1;
    cmask[35] = 1'b1;
    cmask[87] = 1'b1;
    pixels(0, 35);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_stored_not_visible got=%b exp=0", m_valid); end
    pixels(36, 36);
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'h803) begin bad++; $display("FAIL basic_first_word valid=%b data=%h exp=1/00000803", m_valid, m_data); end
    pixels(37, 127);
    step();
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_trailer_early got=%b exp=0", m_valid); end
    step();
    total++;
    if (m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== 32'h2) begin
      bad++; $display("FAIL basic_trailer_timing valid=%b last=%b data=%h exp=1/1/00000002", m_valid, m_last, m_data);
    end
    idle(3);
    exp = '{33'h0_0000_0803, 33'h0_0000_1407, 33'h1_0000_0002};
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      total++;
      if (g !== exp[i]) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, g, exp[i]); end
    end
  endtask
  task automatic test_overflow;
    logic [32:0] exp [$];
    logic [32:0] g;
    do_reset();
    for (int i = 10; i <= 19; i++) cmask[i] = 1'b1;
    pixels(0, 127);
    total += 3;
    if (level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", level); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (m_valid !== 1'b1 || m_data !== 32'hA) begin bad++; $display("FAIL ovf_head valid=%b data=%h exp=1/0000000a", m_valid, m_data); end
    m_ready = 1'b1;
    idle(14);
    total += 2;
    if (level !== 4'd0) begin bad++; $display("FAIL ovf_drained_level got=%0d exp=0", level); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    for (int i = 10; i <= 17; i++) exp.push_back({1'b0, 12'h0, 10'(i / C), 10'(i % C)});
    exp.push_back(33'h1_0002_0008);
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      total++;
      if (g !== exp[i]) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", i, g, exp[i]); end
    end
  endtask
  task automatic test_eof_full;
    logic [32:0] exp [$];
    logic [32:0] g;
    do_reset();
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL eoffull_ovf_cleared got=%b exp=0", overflow); end
    for (int i = 10; i <= 17; i++) cmask[i] = 1'b1;
    pixels(0, 127);
    set_pix(5, 1'b1);
    step();
    total += 2;
    if (level !== 4'd8) begin bad++; $display("FAIL eoffull_pending_level got=%0d exp=8", level); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL eoffull_drop_flag got=%b exp=1", overflow); end
    set_pix(0, 1'b0);
    m_ready = 1'b1;
    step();
    total++;
    if (level !== 4'd7) begin bad++; $display("FAIL eoffull_after_pop got=%0d exp=7", level); end
    m_ready = 1'b0;
    step();
    total++;
    if (level !== 4'd8) begin bad++; $display("FAIL eoffull_trailer_write got=%0d exp=8", level); end
    m_ready = 1'b1;
    idle(12);
    foreach (cmask[i]) cmask[i] = 1'b0;
    pixels(0, 127);
    idle(5);
    for (int i = 10; i <= 17; i++) exp.push_back({1'b0, 12'h0, 10'(i / C), 10'(i % C)});
    exp.push_back(33'h1_0000_0008);
    exp.push_back(33'h1_0001_0000);
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL eoffull_count got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      total++;
      if (g !== exp[i]) begin bad++; $display("FAIL eoffull_word%0d got=%h exp=%h", i, g, exp[i]); end
    end
  endtask
  task automatic test_back_pressure;
    logic [32:0] exp [$];
    logic [32:0] g;
    logic held, hl;
    logic [31:0] hd;
    int run;
    do_reset();
    held = 1'b0;
    hl = 1'b0;
    hd = '0;
    run = 0;
    for (int i = 0; i < 160; i++) begin
      if (held) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== hd || m_last !== hl) begin
          bad++; $display("FAIL bp_stall_hold cycle=%0d valid=%b data=%h last=%b exp=1/%h/%b", i, m_valid, m_data, m_last, hd, hl);
        end
      end
      m_ready = (run >= 3) ? 1'b1 : 1'($urandom_range(1));
      run = m_ready ? 0 : run + 1;
      if (i < 128) set_pix(i, i % 4 == 1);
      else set_pix(0, 1'b0);
      if (i < 128 && i % 4 == 1) exp.push_back({1'b0, 12'h0, 10'(i / C), 10'(i % C)});
      held = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      step();
    end
    m_ready = 1'b1;
    idle(10);
    exp.push_back(33'h1_0000_0020);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow got=%b exp=0", overflow); end
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      total++;
      if (g !== exp[i]) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, g, exp[i]); end
    end
  endtask
  task automatic test_reset_mid;
    logic [32:0] exp [$];
    logic [32:0] g;
    do_reset();
    for (int i = 10; i <= 14; i++) cmask[i] = 1'b1;
    pixels(0, 40);
    total++;
    if (level !== 4'd5 || m_valid !== 1'b1) begin bad++; $display("FAIL rmid_buffered level=%0d valid=%b exp=5/1", level, m_valid); end
    rst = 1'b1;
    set_pix(41, 1'b0);
    step();
    rst = 1'b0;
    got.delete();
    total += 4;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", m_valid); end
    if (level !== 4'd0) begin bad++; $display("FAIL rmid_level got=%0d exp=0", level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_overflow got=%b exp=0", overflow); end
    if (m_data !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", m_data); end
    foreach (cmask[i]) cmask[i] = 1'b0;
    cmask[50] = 1'b1;
    cmask[60] = 1'b1;
    m_ready = 1'b1;
    pixels(42, 127);
    idle(5);
    exp = '{33'h0_0000_0C02, 33'h0_0000_0C0C, 33'h1_0000_0002};
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      total++;
      if (g !== exp[i]) begin bad++; $display("FAIL rmid_word%0d got=%h exp=%h", i, g, exp[i]); end
    end
  endtask
  task automatic test_eof_coincide;
    logic [32:0] exp [$];
    logic [32:0] g;
    do_reset();
    m_ready = 1'b1;
    cmask[20] = 1'b1;
    cmask[127] = 1'b1;
    pixels(0, 127);
    set_pix(127, 1'b0);
    step();
    step();
    idle(6);
    exp = '{33'h0_0000_0404, 33'h0_0000_1C0F, 33'h1_0000_0002};
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL coin_count got=%0d exp=%0d", got.size(), exp.size()); end
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      total++;
      if (g !== exp[i]) begin bad++; $display("FAIL coin_word%0d got=%h exp=%h", i, g, exp[i]); end
    end
  endtask
  initial begin
    rst = 1'b1;
    iscorner = 1'b0;
    m_ready = 1'b0;
    x_coord = '0;
    y_coord = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_eof_full();
    test_back_pressure();
    test_reset_mid();
    test_eof_coincide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
